march_bist_ctrl: RTL and testbench
==================================

Name: march_bist_ctrl

Overview:
- Memory BIST initiator that drives the single-port test memory interface (write_read, address, wdata) and checks rdata.
- Runs a March C- algorithm over a configurable address range and captures the first failing address, element and data.
- Counts all miscompares; sits between the top-level test sequencer (start/done) and the memory under test.

Parameters:
DATA_WIDTH, 8, memory word width
ADDR_WIDTH, 4, memory address width
LAST_ADDR, 2**ADDR_WIDTH-1, highest address tested (range 0..LAST_ADDR, N = LAST_ADDR+1)
CNT_WIDTH, 8, fail_count width

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to begin a test run
busy  out  1  high while test running/draining
done  out  1  one-cycle pulse at end of run
fail  out  1  sticky; set on any miscompare in current run
fail_addr  out  ADDR_WIDTH  address of first miscompare
fail_element  out  3  March element index (0..5) of first miscompare
fail_rdata  out  DATA_WIDTH  rdata of first miscompare
fail_count  out  CNT_WIDTH  saturating miscompare count
write_read  out  1  1 = write, 0 = read
address  out  ADDR_WIDTH  memory address
wdata  out  DATA_WIDTH  write data (one-cycle lead, see below)
rdata  in  DATA_WIDTH  memory read data

Behaviour:
- Reset: all outputs 0, FSM to IDLE, write_read=0, address=0, wdata=0.
- Memory timing contract:
  - Write data leads by one cycle: wdata driven in cycle t is the data for the write issued (write_read=1) in cycle t+1.
  - Read latency is 2: rdata for a read issued in cycle t is valid and compared in cycle t+2.
- Algorithm, background B0 = all 0s, B1 = all 1s:
  - M0 up(w0)
  - M1 up(r0,w1)
  - M2 up(r1,w0)
  - M3 down(r0,w1)
  - M4 down(r1,w0)
  - M5 up(r0)
  - "up" = 0..LAST_ADDR; "down" = LAST_ADDR..0.
  - Each op takes one cycle, no idle cycles between ops or elements. Total 10N op cycles.
- Within a two-op element: read addr A in cycle t, write addr A in cycle t+1, next address in cycle t+2.
- FSM:
  - IDLE: busy=0. start -> RUN with element=0, address=0. wdata already 0, which is the M0 background.
  - RUN: issue ops; address counter wraps between elements without a gap. After the last M5 read -> DRAIN.
  - DRAIN: 2 cycles to retire outstanding reads -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- busy high for exactly 10N+2 cycles, starting the cycle after start is sampled.
- Compare pipeline:
  - 2-deep shift of {valid, expected, address, element} aligned to rdata.
  - Miscompare when valid and rdata != expected.
  - First miscompare of a run loads fail_addr/fail_element/fail_rdata and sets fail.
  - Later miscompares only increment fail_count, which saturates at 2**CNT_WIDTH-1.
- start while busy or in DONE: ignored.
- start in IDLE clears fail, fail_* and fail_count, then begins the run. Results are held until the next start.
- Reset mid-run: immediate return to IDLE, outstanding compares discarded, outputs 0.
- In IDLE/DRAIN/DONE: write_read=0, address holds last value, no writes are issued.

Decomposition:
- Shared package march_pkg:
  - FSM state enum (IDLE, RUN, DRAIN, DONE)
  - element encoding constants M0..M5
  - per-element constants: direction, op count, read-expected background, write background
- One natural sub-module, march_cmp_pipe: the 2-stage expected/address/element delay line plus compare and fail capture.
- Address/op sequencing stays in the top.

Test Plan:
- Fault-free memory, DATA_WIDTH=8, LAST_ADDR=15, pulse start -> busy high exactly 162 cycles, done pulse, fail=0, fail_count=0.
- Fault-free, check bus trace -> first 16 cycles: write_read=1, address 0..15. M3 starts at address 15. wdata=0xFF in the cycle before each M1 write.
- Bit 2 stuck-at-0 at address 5 -> fail=1, fail_addr=5, fail_element=2, fail_rdata=0xFB, fail_count=2 (M2 and M4 reads).
- Same fault, second start after done -> fail and counters cleared at start, identical results reproduced.
- Assert rst in mid-M3 -> all outputs 0 next cycle. Following start gives a complete clean 162-cycle run.
- CNT_WIDTH=2, all cells stuck-at-0 -> fail_count saturates at 3. fail_addr=0, fail_element=2, fail_rdata=0x00.

Source files
------------

// File: rtl/march_pkg.sv
// Shared types and per-element constants for the March C- BIST controller.
package march_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [2:0] M0 = 3'd0;
   localparam logic [2:0] M1 = 3'd1;
   localparam logic [2:0] M2 = 3'd2;
   localparam logic [2:0] M3 = 3'd3;
   localparam logic [2:0] M4 = 3'd4;
   localparam logic [2:0] M5 = 3'd5;

   // Per-element flags, bit index = element number (bits 6/7 unused).
   // Direction: 1 = down (LAST_ADDR..0).
   localparam logic [7:0] ELEM_DOWN     = 8'b0001_1000;
   // Two ops per address (read then write) versus a single op.
   localparam logic [7:0] ELEM_TWO_OP   = 8'b0001_1110;
   // Element starts each address with a read (only M0 is write-only).
   localparam logic [7:0] ELEM_HAS_READ = 8'b0011_1110;
   // Expected read background is all ones.
   localparam logic [7:0] ELEM_RD_ONES  = 8'b0001_0100;
   // Write background is all ones.
   localparam logic [7:0] ELEM_WR_ONES  = 8'b0000_1010;

endpackage

// File: rtl/march_bist_ctrl_if.sv
// Single-port test memory bus between the BIST initiator and the memory.
interface march_bist_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  write_read;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (output write_read, output address, output wdata, input rdata);
   modport slave  (input write_read, input address, input wdata, output rdata);
endinterface

// File: rtl/march_cmp_pipe.sv
// Two-stage delay line aligning expected data with 2-cycle read data,
// plus first-failure capture and saturating miscompare count.
module march_cmp_pipe #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  issue_valid,
   input  logic [DATA_WIDTH-1:0] issue_exp,
   input  logic [ADDR_WIDTH-1:0] issue_addr,
   input  logic [2:0]            issue_elem,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [2:0]            fail_element,
   output logic [DATA_WIDTH-1:0] fail_rdata,
   output logic [CNT_WIDTH-1:0]  fail_count
);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic                  s1_vld, s2_vld;
   logic [DATA_WIDTH-1:0] s1_exp, s2_exp;
   logic [ADDR_WIDTH-1:0] s1_addr, s2_addr;
   logic [2:0]            s1_elem, s2_elem;
   logic                  miscompare;

   assign miscompare = s2_vld && (rdata != s2_exp);

   // Shift read descriptors so stage 2 lines up with returning rdata.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s2_vld  <= 1'b0;
         s1_exp  <= '0;
         s2_exp  <= '0;
         s1_addr <= '0;
         s2_addr <= '0;
         s1_elem <= '0;
         s2_elem <= '0;
      end else begin
         s1_vld  <= issue_valid;
         s1_exp  <= issue_exp;
         s1_addr <= issue_addr;
         s1_elem <= issue_elem;
         s2_vld  <= s1_vld;
         s2_exp  <= s1_exp;
         s2_addr <= s1_addr;
         s2_elem <= s1_elem;
      end
   end

   // Capture the first miscompare of a run and count all of them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail         <= 1'b0;
         fail_addr    <= '0;
         fail_element <= '0;
         fail_rdata   <= '0;
         fail_count   <= '0;
      end else if (clear) begin
         fail         <= 1'b0;
         fail_addr    <= '0;
         fail_element <= '0;
         fail_rdata   <= '0;
         fail_count   <= '0;
      end else if (miscompare) begin
         if (!fail) begin
            fail         <= 1'b1;
            fail_addr    <= s2_addr;
            fail_element <= s2_elem;
            fail_rdata   <= rdata;
         end
         if (fail_count != CNT_MAX) begin
            fail_count <= fail_count + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- memory BIST initiator: sequences ops over 0..LAST_ADDR and
// checks read data through march_cmp_pipe.
//
//  state   | meaning
//  --------+------------------------------------------------------
//  S_IDLE  | waiting for start; bus idle, results held
//  S_RUN   | one memory op per cycle across elements M0..M5
//  S_DRAIN | two cycles retiring the final outstanding reads
//  S_DONE  | one-cycle done pulse, then back to idle
module march_bist_ctrl
   import march_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int LAST_ADDR  = 2**ADDR_WIDTH-1,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [2:0]            fail_element,
   output logic [DATA_WIDTH-1:0] fail_rdata,
   output logic [CNT_WIDTH-1:0]  fail_count,
   march_bist_ctrl_if.master     mem
);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(LAST_ADDR);

   state_t                state;
   logic [2:0]            elem;
   logic                  phase;
   logic                  drain_cnt;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  write_read;
   logic [DATA_WIDTH-1:0] wdata;

   logic [2:0]            elem_nxt;
   logic                  at_end;
   logic                  last_op_at_addr;
   logic                  run_start;
   logic                  issue_valid;

   assign mem.write_read = write_read;
   assign mem.address    = addr;
   assign mem.wdata      = wdata;

   // Position within the current element.
   always_comb begin
      elem_nxt        = elem + 3'd1;
      at_end          = ELEM_DOWN[elem] ? (addr == '0) : (addr == ADDR_MAX);
      last_op_at_addr = !ELEM_TWO_OP[elem] || phase;
   end

   assign run_start   = (state == S_IDLE) && start;
   assign issue_valid = (state == S_RUN) && !write_read;

   // Sequencer FSM; every bus output is registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         elem       <= M0;
         phase      <= 1'b0;
         drain_cnt  <= 1'b0;
         addr       <= '0;
         write_read <= 1'b0;
         wdata      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_RUN;
                  busy       <= 1'b1;
                  elem       <= M0;
                  phase      <= 1'b0;
                  addr       <= '0;
                  write_read <= 1'b1;
                  wdata      <= '0;
               end
            end
            S_RUN: begin
               if (!last_op_at_addr) begin
                  phase      <= 1'b1;
                  write_read <= 1'b1;
               end else if (!at_end) begin
                  phase      <= 1'b0;
                  addr       <= ELEM_DOWN[elem] ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
                  write_read <= !ELEM_HAS_READ[elem];
               end else if (elem == M5) begin
                  state      <= S_DRAIN;
                  drain_cnt  <= 1'b0;
                  write_read <= 1'b0;
               end else begin
                  // Write data leads by a cycle, so the new background
                  // must be on wdata from the element's first cycle.
                  elem       <= elem_nxt;
                  phase      <= 1'b0;
                  addr       <= ELEM_DOWN[elem_nxt] ? ADDR_MAX : '0;
                  write_read <= !ELEM_HAS_READ[elem_nxt];
                  wdata      <= {DATA_WIDTH{ELEM_WR_ONES[elem_nxt]}};
               end
            end
            S_DRAIN: begin
               if (drain_cnt) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   march_cmp_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_cmp (
      .clk          (clk),
      .rst          (rst),
      .clear        (run_start),
      .issue_valid  (issue_valid),
      .issue_exp    ({DATA_WIDTH{ELEM_RD_ONES[elem]}}),
      .issue_addr   (addr),
      .issue_elem   (elem),
      .rdata        (mem.rdata),
      .fail         (fail),
      .fail_addr    (fail_addr),
      .fail_element (fail_element),
      .fail_rdata   (fail_rdata),
      .fail_count   (fail_count)
   );

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Bench for march_bist_ctrl: faulty-memory model plus a March C- reference.
module tb_march_bist_ctrl;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int N  = 16;
   localparam int CW = 2;
   localparam int OPS = 10 * N;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy, done, fail;
   logic [AW-1:0] fail_addr;
   logic [2:0]    fail_element;
   logic [DW-1:0] fail_rdata;
   logic [CW-1:0] fail_count;

   int checks = 0;
   int errors = 0;

   march_bist_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_bus ();

   march_bist_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .LAST_ADDR  (N-1),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .fail         (fail),
      .fail_addr    (fail_addr),
      .fail_element (fail_element),
      .fail_rdata   (fail_rdata),
      .fail_count   (fail_count),
      .mem          (mem_bus)
   );

   always #5 clk = ~clk;

   // Memory with stuck-at masks on the read path, 2-cycle read latency,
   // write data taken from the previous cycle's wdata.
   logic [DW-1:0] mem_arr [N];
   logic [DW-1:0] s0_mask [N];
   logic [DW-1:0] s1_mask [N];
   logic [DW-1:0] wdata_d, rd_pipe;

   always @(posedge clk) begin
      wdata_d <= mem_bus.wdata;
      if (mem_bus.write_read) mem_arr[mem_bus.address] <= wdata_d;
      rd_pipe       <= (mem_arr[mem_bus.address] & ~s0_mask[mem_bus.address]) | s1_mask[mem_bus.address];
      mem_bus.rdata <= rd_pipe;
   end

   // Reference: expected op trace and run results.
   logic          op_wr_q [$];
   int            op_addr_q [$];
   logic [DW-1:0] op_data_q [$];
   logic          exp_fail;
   int            exp_addr, exp_elem, exp_cnt;
   logic [DW-1:0] exp_rdata;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic build_model();
      logic [DW-1:0] m [N];
      logic [DW-1:0] want, got, wv;
      int a;
      op_wr_q.delete();
      op_addr_q.delete();
      op_data_q.delete();
      exp_fail = 1'b0; exp_addr = 0; exp_elem = 0; exp_rdata = '0; exp_cnt = 0;
      for (int e = 0; e < 6; e++) begin
         for (int k = 0; k < N; k++) begin
            a = (e == 3 || e == 4) ? N-1-k : k;
            if (e != 0) begin
               want = (e == 2 || e == 4) ? '1 : '0;
               got  = (m[a] & ~s0_mask[a]) | s1_mask[a];
               op_wr_q.push_back(1'b0); op_addr_q.push_back(a); op_data_q.push_back('0);
               if (got !== want) begin
                  if (!exp_fail) begin
                     exp_fail = 1'b1; exp_addr = a; exp_elem = e; exp_rdata = got;
                  end
                  exp_cnt++;
               end
            end
            if (e != 5) begin
               wv = (e == 1 || e == 3) ? '1 : '0;
               m[a] = wv;
               op_wr_q.push_back(1'b1); op_addr_q.push_back(a); op_data_q.push_back(wv);
            end
         end
      end
      if (exp_cnt > 3) exp_cnt = 3;
   endtask

   task automatic run_and_check(input string name, input int ign_k, input logic start_in_done);
      logic [DW-1:0] prev_wdata;
      build_model();
      @(negedge clk);
      check({name, " idle_busy"}, 64'(busy), 64'(0));
      start = 1'b1;
      prev_wdata = mem_bus.wdata;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < OPS; k++) begin
         check({name, " run_busy_done"}, 64'({busy, done}), 64'(2'b10));
         check({name, " write_read"}, 64'(mem_bus.write_read), 64'(op_wr_q[k]));
         check({name, " address"}, 64'(mem_bus.address), 64'(op_addr_q[k]));
         if (op_wr_q[k]) check({name, " wdata_lead"}, 64'(prev_wdata), 64'(op_data_q[k]));
         prev_wdata = mem_bus.wdata;
         start = (k == ign_k);
         @(negedge clk);
      end
      start = 1'b0;
      for (int d = 0; d < 2; d++) begin
         check({name, " drain"}, 64'({busy, done, mem_bus.write_read}), 64'(3'b100));
         @(negedge clk);
      end
      check({name, " done_pulse"}, 64'({busy, done}), 64'(2'b01));
      check({name, " fail"}, 64'(fail), 64'(exp_fail));
      check({name, " fail_addr"}, 64'(fail_addr), 64'(exp_addr));
      check({name, " fail_element"}, 64'(fail_element), 64'(exp_elem));
      check({name, " fail_rdata"}, 64'(fail_rdata), 64'(exp_rdata));
      check({name, " fail_count"}, 64'(fail_count), 64'(exp_cnt));
      start = start_in_done;
      @(negedge clk);
      start = 1'b0;
      check({name, " back_idle"}, 64'({busy, done, mem_bus.write_read}), 64'(0));
      @(negedge clk);
      check({name, " still_idle"}, 64'(busy), 64'(0));
      check({name, " held_count"}, 64'(fail_count), 64'(exp_cnt));
      check({name, " held_addr"}, 64'(fail_addr), 64'(exp_addr));
   endtask

   task automatic clear_faults();
      for (int a = 0; a < N; a++) begin
         s0_mask[a] = '0;
         s1_mask[a] = '0;
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      clear_faults();
      repeat (3) @(negedge clk);
      check("reset_outputs", {busy, done, fail, fail_addr, fail_element, fail_rdata, fail_count,
                              mem_bus.write_read, mem_bus.address, mem_bus.wdata}, 64'(0));
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_idle", 64'({busy, done, mem_bus.write_read}), 64'(0));

      run_and_check("clean", -1, 1'b0);

      s0_mask[5] = 8'h04;
      run_and_check("bit2_sa0", 37, 1'b1);
      run_and_check("bit2_sa0_rerun", -1, 1'b0);

      // Reset in the middle of M3 (ops 80..111), after the fault was seen.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (90) @(negedge clk);
      check("pre_reset_fail", 64'({busy, fail}), 64'(2'b11));
      rst = 1'b1;
      #1;
      check("mid_reset_outputs", {busy, done, fail, fail_addr, fail_element, fail_rdata, fail_count,
                                  mem_bus.write_read, mem_bus.address, mem_bus.wdata}, 64'(0));
      @(negedge clk);
      check("mid_reset_hold", {busy, done, fail, fail_count, mem_bus.write_read, mem_bus.address}, 64'(0));
      rst = 1'b0;
      clear_faults();
      run_and_check("after_reset", -1, 1'b0);

      for (int a = 0; a < N; a++) s0_mask[a] = '1;
      run_and_check("all_sa0_sat", OPS-1, 1'b0);

      for (int it = 0; it < 6; it++) begin
         clear_faults();
         for (int a = 0; a < N; a++) begin
            if ($urandom_range(0, 7) == 0) s0_mask[a] = DW'($urandom);
            if ($urandom_range(0, 7) == 0) s1_mask[a] = DW'($urandom);
         end
         run_and_check("random", ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, OPS-1)) : -1,
                       1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
